// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit core.
// Owns the PC, fetches from a combinational instruction memory, sequences a
// register file (two async read ports, one sync write port) and runs
// ADD/SUB/LDI/BNE/OUT/HALT. OUT results leave through a valid/ready port.
//
// Ports:
//   clk, reset               rising-edge clock, async active-high reset
//   run                      fetch enable, sampled only in FETCH
//   imem_addr / imem_instr   instruction address (= pc) / instruction word
//   rf_ra1, rf_ra2           read addresses IR[12:10] (rd), IR[9:7] (rs)
//   rf_rd1, rf_rd2           async read data
//   rf_we, rf_wa, rf_wd      one-cycle write pulse, address, data
//   out_valid, out_data      OUT port, held until out_ready is sampled high
//   out_ready                consumer accept
//   halted                   high while in HALT
//   state_dbg                current state encoding
module cpu_sequencer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PC_WIDTH   = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [15:0]           imem_instr,
    output logic [2:0]            rf_ra1,
    output logic [2:0]            rf_ra2,
    input  logic [DATA_WIDTH-1:0] rf_rd1,
    input  logic [DATA_WIDTH-1:0] rf_rd2,
    output logic                  rf_we,
    output logic [2:0]            rf_wa,
    output logic [DATA_WIDTH-1:0] rf_wd,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  halted,
    output logic [2:0]            state_dbg
);

    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned IMM_WIDTH   = 10;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_OUT  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_BNE  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_OUT    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                  state, state_n;
    logic [PC_WIDTH-1:0]     pc, pc_n;
    logic [INSTR_WIDTH-1:0]  ir, ir_n;
    logic [DATA_WIDTH-1:0]   a, a_n;
    logic [DATA_WIDTH-1:0]   b, b_n;
    logic [DATA_WIDTH-1:0]   res_n;

    logic [2:0]              opcode;
    logic [PC_WIDTH-1:0]     br_off;
    logic [PC_WIDTH-1:0]     pc_inc;

    assign opcode = ir[15:13];
    assign br_off = {{(PC_WIDTH-IMM_WIDTH){ir[IMM_WIDTH-1]}}, ir[IMM_WIDTH-1:0]};
    assign pc_inc = pc + PC_WIDTH'(1);

    // Register addresses come straight from IR so the async read data is
    // already settled by the time DECODE latches A and B.
    assign imem_addr = pc;
    assign rf_ra1    = ir[12:10];
    assign rf_ra2    = ir[9:7];
    assign state_dbg = state;

    // Next-state and datapath
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        a_n     = a;
        b_n     = b;
        res_n   = '0;
        unique case (state)
            S_FETCH: begin
                if (run) begin
                    ir_n    = imem_instr;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                a_n     = rf_rd1;
                b_n     = rf_rd2;
                state_n = S_EXEC;
            end
            S_EXEC: begin
                unique case (opcode)
                    OP_ADD: begin
                        res_n   = a + b;
                        state_n = S_WB;
                    end
                    OP_SUB: begin
                        res_n   = a - b;
                        state_n = S_WB;
                    end
                    OP_LDI: begin
                        res_n   = DATA_WIDTH'(ir[IMM_WIDTH-1:0]);
                        state_n = S_WB;
                    end
                    OP_BNE: begin
                        // Offset is relative to the BNE's own address.
                        pc_n    = (a != '0) ? (pc + br_off) : pc_inc;
                        state_n = S_FETCH;
                    end
                    OP_OUT:  state_n = S_OUT;
                    OP_HALT: state_n = S_HALT;
                    default: begin
                        // Reserved opcodes behave as NOP.
                        pc_n    = pc_inc;
                        state_n = S_FETCH;
                    end
                endcase
            end
            S_WB: begin
                pc_n    = pc_inc;
                state_n = S_FETCH;
            end
            S_OUT: begin
                if (out_ready) begin
                    pc_n    = pc_inc;
                    state_n = S_FETCH;
                end
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    // State, datapath and registered outputs; outputs are decoded from the
    // next state so they are valid exactly while the FSM sits in WB/OUT/HALT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            rf_we     <= 1'b0;
            rf_wa     <= '0;
            rf_wd     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ir        <= ir_n;
            a         <= a_n;
            b         <= b_n;
            rf_we     <= (state_n == S_WB);
            rf_wa     <= (state_n == S_WB) ? ir[12:10] : 3'd0;
            rf_wd     <= res_n;
            out_valid <= (state_n == S_OUT);
            out_data  <= (state_n == S_OUT) ? a : '0;
            halted    <= (state_n == S_HALT);
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: instruction-level reference model with per-
// instruction cycle budgets, directed programs with literal expectations,
// then randomized programs, run/out_ready and reset activity.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic [2:0]  rf_ra1, rf_ra2, rf_wa;
    logic [15:0] rf_rd1, rf_rd2, rf_wd, out_data;
    logic        rf_we, out_valid, halted;
    logic [2:0]  state_dbg;

    logic [15:0] imem [65536];
    logic [15:0] rf [8] = '{default: 16'h0000};

    int n_vec = 0;
    int n_fail = 0;
    int cnt_ov = 0;
    int cnt_we = 0;

    cpu_sequencer #(.DATA_WIDTH(16), .PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .halted(halted), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Environment: combinational imem, async-read / sync-write register file
    assign imem_instr = imem[imem_addr];
    assign rf_rd1     = rf[rf_ra1];
    assign rf_rd2     = rf[rf_ra2];
    always @(posedge clk) if (rf_we) rf[rf_wa] <= rf_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs);
        return {op, rd, rs, 7'd0};
    endfunction
    function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd, input logic [9:0] imm);
        return {op, rd, imm};
    endfunction

    // ---------------- reference model ----------------
    // Each instruction's effect is computed in one step when it is fetched;
    // afterwards only its cycle budget is counted down. kind: 0 = register
    // write (4 cycles), 1 = branch/NOP (3 cycles), 2 = OUT (3 + wait), 3 = HALT.
    logic [15:0] m_pc = 16'h0, m_ins = 16'h0, m_a = 16'h0, m_res = 16'h0, m_npc = 16'h0;
    logic [15:0] m_regs [8] = '{default: 16'h0000};
    int          m_c = 0;
    int          m_kind = 0;
    bit          m_halt = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 16'h0; m_ins = 16'h0; m_c = 0; m_halt = 1'b0; m_kind = 0;
        end else if (!m_halt) begin
            if (m_c == 0) begin
                if (run) begin
                    logic [15:0] bv, sx;
                    m_ins = imem[m_pc];
                    m_a   = m_regs[m_ins[12:10]];
                    bv    = m_regs[m_ins[9:7]];
                    sx    = {{6{m_ins[9]}}, m_ins[9:0]};
                    m_npc = m_pc + 16'd1;
                    m_kind = 1;
                    case (m_ins[15:13])
                        3'b000: begin m_kind = 0; m_res = m_a + bv; end
                        3'b001: begin m_kind = 0; m_res = m_a - bv; end
                        3'b101: begin m_kind = 0; m_res = {6'd0, m_ins[9:0]}; end
                        3'b110: if (m_a != 16'h0) m_npc = m_pc + sx;
                        3'b100: m_kind = 2;
                        3'b111: m_kind = 3;
                        default: m_kind = 1;
                    endcase
                    m_c = 1;
                end
            end else if (m_c == 1) begin
                m_c = 2;
            end else if (m_c == 2) begin
                if (m_kind == 1) begin m_pc = m_npc; m_c = 0; end
                else if (m_kind == 3) m_halt = 1'b1;
                else m_c = 3;
            end else begin
                if (m_kind == 0) begin
                    m_regs[m_ins[12:10]] = m_res;
                    m_pc = m_npc; m_c = 0;
                end else if (out_ready) begin
                    m_pc = m_npc; m_c = 0;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        logic [2:0] exp_state;
        logic       exp_we, exp_ov;
        exp_state = m_halt ? 3'd5 : (m_c < 3) ? 3'(m_c) : (m_kind == 0) ? 3'd3 : 3'd4;
        exp_we    = !m_halt && m_c == 3 && m_kind == 0;
        exp_ov    = !m_halt && m_c == 3 && m_kind == 2;
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("state_dbg", 32'(state_dbg), 32'(exp_state));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("rf_ra1", 32'(rf_ra1), 32'(m_ins[12:10]));
        chk("rf_ra2", 32'(rf_ra2), 32'(m_ins[9:7]));
        chk("rf_we", 32'(rf_we), 32'(exp_we));
        if (exp_we) begin
            chk("rf_wa", 32'(rf_wa), 32'(m_ins[12:10]));
            chk("rf_wd", 32'(rf_wd), 32'(m_res));
        end
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) chk("out_data", 32'(out_data), 32'(m_a));
        if (out_valid) cnt_ov++;
        if (rf_we) cnt_we++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 65536; i++) imem[i] = 16'hE000;
    endtask

    task automatic enter_reset();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int ov0, we0;
        fill_halt();

        // Reset state
        ticks(3);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'h0);
        chk("rst_outs", {16'(out_data), 8'(rf_wd), 1'b0, rf_we, out_valid, halted, 1'b0, rf_wa}, 32'h0);

        // run=0 holds in FETCH
        reset = 1'b0;
        ticks(5);
        chk("run0_state", 32'(state_dbg), 32'h0);
        chk("run0_pc", 32'(imem_addr), 32'h0);

        // Counting loop program
        enter_reset();
        imem[0] = enc_i(3'b101, 3'd0, 10'd2);
        imem[1] = enc_i(3'b101, 3'd1, 10'd2);
        imem[2] = enc_i(3'b101, 3'd2, 10'd0);
        imem[3] = enc_i(3'b101, 3'd3, 10'd1);
        imem[4] = enc_r(3'b000, 3'd2, 3'd0);
        imem[5] = enc_r(3'b001, 3'd1, 3'd3);
        imem[6] = enc_i(3'b110, 3'd1, 10'h3FE);
        imem[7] = enc_r(3'b100, 3'd2, 3'd0);
        imem[8] = 16'hE000;
        run = 1'b1; out_ready = 1'b1;
        ov0 = cnt_ov;
        reset = 1'b0;
        ticks(40);
        chk("loop_ov_c40", 32'(out_valid), 32'h0);
        tick();
        chk("loop_ov_c41", 32'(out_valid), 32'h1);
        chk("loop_out_data", 32'(out_data), 32'h4);
        ticks(10);
        chk("loop_halted", 32'(halted), 32'h1);
        chk("loop_pc", 32'(imem_addr), 32'h8);
        chk("loop_ov_count", 32'(cnt_ov - ov0), 32'h1);
        chk("loop_r2", 32'(rf[2]), 32'h4);

        // Reset during EXEC of an ADD aborts the write
        enter_reset();
        fill_halt();
        imem[0] = enc_r(3'b000, 3'd2, 3'd0);
        we0 = cnt_we;
        reset = 1'b0;
        ticks(2);
        chk("add_in_exec", 32'(state_dbg), 32'h2);
        reset = 1'b1;
        #1;
        chk("abort_state", 32'(state_dbg), 32'h0);
        chk("abort_outs", {16'(out_data), 8'(rf_wd), 1'b0, rf_we, out_valid, halted, 1'b0, rf_wa}, 32'h0);
        ticks(2);
        run = 1'b0;
        reset = 1'b0;
        ticks(3);
        chk("abort_pc", 32'(imem_addr), 32'h0);
        chk("abort_no_we", 32'(cnt_we - we0), 32'h0);
        chk("abort_r2", 32'(rf[2]), 32'h4);

        // BNE taken with offset 0x3FF from pc 0 wraps to 0xFFFF
        enter_reset();
        imem[0] = enc_i(3'b101, 3'd1, 10'd5);
        run = 1'b1;
        reset = 1'b0;
        ticks(10);
        enter_reset();
        imem[0] = enc_i(3'b110, 3'd1, 10'h3FF);
        reset = 1'b0;
        ticks(3);
        chk("bne_wrap_pc", 32'(imem_addr), 32'hFFFF);

        // Reserved opcodes as NOP, then BNE with A=0 at pc 5
        enter_reset();
        fill_halt();
        for (int i = 0; i < 5; i++) imem[i] = (i % 2 == 0) ? 16'h4000 : 16'h6000;
        imem[5] = enc_i(3'b110, 3'd6, 10'd7);
        ov0 = cnt_ov; we0 = cnt_we;
        reset = 1'b0;
        ticks(15);
        chk("nop_pc", 32'(imem_addr), 32'h5);
        chk("nop_no_we", 32'(cnt_we - we0), 32'h0);
        chk("nop_no_ov", 32'(cnt_ov - ov0), 32'h0);
        ticks(3);
        chk("bne_nt_pc", 32'(imem_addr), 32'h6);

        // LDI r7,#0x3FF writes for exactly one cycle
        enter_reset();
        fill_halt();
        imem[0] = enc_i(3'b101, 3'd7, 10'h3FF);
        we0 = cnt_we;
        reset = 1'b0;
        ticks(3);
        chk("ldi_we", 32'(rf_we), 32'h1);
        chk("ldi_wa", 32'(rf_wa), 32'h7);
        chk("ldi_wd", 32'(rf_wd), 32'h03FF);
        tick();
        chk("ldi_we_drop", 32'(rf_we), 32'h0);
        chk("ldi_pc", 32'(imem_addr), 32'h1);
        chk("ldi_we_count", 32'(cnt_we - we0), 32'h1);

        // SUB 0-1
        enter_reset();
        imem[0] = enc_i(3'b101, 3'd4, 10'd0);
        imem[1] = enc_i(3'b101, 3'd5, 10'd1);
        imem[2] = enc_r(3'b001, 3'd4, 3'd5);
        reset = 1'b0;
        ticks(11);
        chk("sub_we", 32'(rf_we), 32'h1);
        chk("sub_wd", 32'(rf_wd), 32'hFFFF);

        // OUT with out_ready low for 5 cycles
        enter_reset();
        fill_halt();
        imem[0] = enc_i(3'b101, 3'd2, 10'h123);
        imem[1] = enc_r(3'b100, 3'd2, 3'd0);
        out_ready = 1'b0;
        ov0 = cnt_ov;
        reset = 1'b0;
        ticks(7);
        chk("outw_valid0", 32'(out_valid), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("outw_valid", 32'(out_valid), 32'h1);
            chk("outw_data", 32'(out_data), 32'h0123);
            chk("outw_pc", 32'(imem_addr), 32'h1);
        end
        tick();
        out_ready = 1'b1;
        chk("outw_valid5", 32'(out_valid), 32'h1);
        tick();
        chk("outw_drop", 32'(out_valid), 32'h0);
        chk("outw_pc_inc", 32'(imem_addr), 32'h2);
        chk("outw_count", 32'(cnt_ov - ov0), 32'h6);

        // Randomized programs
        for (int t = 0; t < 10; t++) begin
            enter_reset();
            for (int i = 0; i < 65536; i++) begin
                logic [15:0] w;
                w = 16'($urandom);
                if (w[15:13] == 3'b111 && ($urandom % 8) != 0) w[15:13] = 3'b000;
                imem[i] = w;
            end
            reset = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                run       = ($urandom % 10) != 0;
                out_ready = ($urandom % 2) != 0;
                reset     = ($urandom % 600) == 0;
                tick();
            end
        end

        reset = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
